// File: rtl/terrain_column_server_if.sv
// Crater request handshake between game logic (master) and the terrain column server (slave).
interface terrain_column_server_if #(
  parameter int R_W = 5
);
  logic           crater_req;
  logic [9:0]     CraterX;
  logic [9:0]     CraterY;
  logic [R_W-1:0] CraterR;
  logic           ready;
  logic           carve_done;

  modport master (output crater_req, CraterX, CraterY, CraterR, input ready, carve_done);
  modport slave  (input crater_req, CraterX, CraterY, CraterR, output ready, carve_done);
endinterface

// File: rtl/terrain_column_server.sv
// Destructible terrain heightmap: per-column ground mask for display, crater carving FSM.
// Optional CRATER_QUEUE_EN adds a one-entry pending buffer for requests arriving while busy.
module terrain_column_server #(
  parameter int H_COLS      = 640,
  parameter int V_ROWS      = 480,
  parameter int HEIGHT_INIT = 360,
  parameter int R_W         = 5
) (
  input  logic                           Clk,
  input  logic                           Reset_n,
  input  logic [9:0]                     DrawX,
  output logic [511:0]                   terrain_data,
  terrain_column_server_if.slave         crater
);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_COL, S_GROW, S_WRITE, S_NEXT, S_DONE} state_t;

  function automatic logic [10:0] sq11(input logic [R_W:0] v);
    return 11'(v) * 11'(v);
  endfunction

  logic [8:0]            ram_q [H_COLS];
  state_t                state_q;
  logic [9:0]            init_cnt_q;
  logic [9:0]            cx_q, cy_q, col_q;
  logic [R_W-1:0]        cr_q, h_q;
  logic signed [R_W:0]   dx_q;
  logic                  ready_q, done_q;
  logic                  disp_vld_q;
  logic [8:0]            disp_h_q;

  logic [9:0]            src_x_d, src_y_d;
  logic [R_W-1:0]        src_r_d;
  logic                  launch_d;
  logic signed [10:0]    col_d;
  logic                  col_ok_d;
  logic [R_W:0]          dx_mag_d, hp1_d;
  logic                  grow_d;
  logic [10:0]           sum_d;
  logic [8:0]            nh_d, old_d;
  logic                  we_d;
  logic [9:0]            waddr_d;
  logic [8:0]            wdata_d;
  logic [9:0]            rd_addr_d;

`ifdef CRATER_QUEUE_EN
  logic                  pend_vld_q;
  logic [9:0]            px_q, py_q;
  logic [R_W-1:0]        pr_q;

  always_comb begin
    src_x_d  = pend_vld_q ? px_q : crater.CraterX;
    src_y_d  = pend_vld_q ? py_q : crater.CraterY;
    src_r_d  = pend_vld_q ? pr_q : crater.CraterR;
    launch_d = pend_vld_q || (crater.crater_req && ready_q);
  end
`else
  always_comb begin
    src_x_d  = crater.CraterX;
    src_y_d  = crater.CraterY;
    src_r_d  = crater.CraterR;
    launch_d = crater.crater_req && ready_q;
  end
`endif

  always_comb begin
    col_d    = $signed({1'b0, cx_q}) + $signed({{(10-R_W){dx_q[R_W]}}, dx_q});
    col_ok_d = !col_d[10] && (col_d[9:0] < 10'(H_COLS));
    dx_mag_d = dx_q[R_W] ? (R_W+1)'(-dx_q) : (R_W+1)'(dx_q);
    hp1_d    = {1'b0, h_q} + 1'b1;
    // h == R stops growth explicitly so (R+1)^2 never has to fit in 11 bits
    grow_d   = (h_q != cr_q) &&
               (12'(sq11(hp1_d)) + 12'(sq11(dx_mag_d)) <= 12'(sq11({1'b0, cr_q})));
    sum_d    = 11'(cy_q) + 11'(h_q) + 11'd1;
    nh_d     = (sum_d > 11'(V_ROWS)) ? 9'(V_ROWS) : sum_d[8:0];
    old_d    = ram_q[col_q];
    we_d     = 1'b0;
    waddr_d  = col_q;
    wdata_d  = nh_d;
    if (state_q == S_INIT) begin
      we_d    = Reset_n;
      waddr_d = init_cnt_q;
      wdata_d = 9'(HEIGHT_INIT);
    end else if (state_q == S_WRITE) begin
      we_d    = Reset_n && (nh_d > old_d);
    end
    rd_addr_d = (DrawX < 10'(H_COLS)) ? DrawX : 10'd0;
  end

  always_ff @(posedge Clk) begin
    if (we_d) ram_q[waddr_d] <= wdata_d;
  end

  // Display stage: registered height, decoded to a mask in the next block
  always_ff @(posedge Clk) begin
    disp_h_q <= ram_q[rd_addr_d];
    if (!Reset_n) disp_vld_q <= 1'b0;
    else          disp_vld_q <= (DrawX < 10'(H_COLS));
  end

  always_comb begin
    terrain_data = '0;
    for (int y = 0; y < 512; y++)
      terrain_data[y] = disp_vld_q && (9'(y) >= disp_h_q);
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q    <= S_INIT;
      init_cnt_q <= '0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
`ifdef CRATER_QUEUE_EN
      pend_vld_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_INIT: begin
          init_cnt_q <= init_cnt_q + 10'd1;
          if (init_cnt_q == 10'(H_COLS - 1)) begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
          end
        end
        S_IDLE: if (launch_d) begin
          cx_q    <= src_x_d;
          cy_q    <= src_y_d;
          cr_q    <= src_r_d;
          dx_q    <= -$signed({1'b0, src_r_d});
          state_q <= S_COL;
`ifdef CRATER_QUEUE_EN
          if (pend_vld_q) begin
            pend_vld_q <= 1'b0;
            ready_q    <= 1'b1;
          end
`else
          ready_q <= 1'b0;
`endif
        end
        S_COL: begin
          if (col_ok_d) begin
            col_q   <= col_d[9:0];
            h_q     <= '0;
            state_q <= S_GROW;
          end else begin
            state_q <= S_NEXT;
          end
        end
        S_GROW: begin
          if (grow_d) h_q <= h_q + 1'b1;
          else        state_q <= S_WRITE;
        end
        S_WRITE: state_q <= S_NEXT;
        S_NEXT: begin
          if (dx_q == $signed({1'b0, cr_q})) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            dx_q    <= dx_q + 1'b1;
            state_q <= S_COL;
          end
        end
        S_DONE: begin
`ifdef CRATER_QUEUE_EN
          if (pend_vld_q) begin
            cx_q       <= px_q;
            cy_q       <= py_q;
            cr_q       <= pr_q;
            dx_q       <= -$signed({1'b0, pr_q});
            pend_vld_q <= 1'b0;
            ready_q    <= 1'b1;
            state_q    <= S_COL;
          end else begin
            state_q <= S_IDLE;
          end
`else
          state_q <= S_IDLE;
          ready_q <= 1'b1;
`endif
        end
        default: state_q <= S_INIT;
      endcase
`ifdef CRATER_QUEUE_EN
      // While carving, an accepted request parks in the buffer until DONE
      if (crater.crater_req && ready_q && state_q != S_IDLE) begin
        pend_vld_q <= 1'b1;
        ready_q    <= 1'b0;
        px_q       <= crater.CraterX;
        py_q       <= crater.CraterY;
        pr_q       <= crater.CraterR;
      end
`endif
    end
  end

  assign crater.ready      = ready_q;
  assign crater.carve_done = done_q;

endmodule
